// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle control unit:
// opcodes, FSM states, datapath select codes and the strobe bundle.
package multicycle_control_unit_pkg;

    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_J    = 3'd2;
    localparam logic [2:0] OP_LW   = 3'd4;
    localparam logic [2:0] OP_SW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_ORI  = 3'd7;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_IMMEX  = 4'd8,
        S_IMMWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_out_decode.sv
// Combinational state-to-strobe decoder; only FETCH looks at
// mem_ready, everything else depends on state and latched opcode.
module mcu_out_decode
    import multicycle_control_unit_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] op,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                end
            end
            S_DECODE: ctrl.alu_src_b = SRCB_BOFS;
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_IMMEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (op == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            S_IMMWB: ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_JUMP;
            end
            S_TRAP: ctrl.illegal = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle controller: FSM, opcode latch and retired-instruction
// counter; strobes come from mcu_out_decode.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter bit ENABLE_JUMP = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_o
);

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] retired_q;
    logic             op_hi;
    logic             retire;
    ctrl_t            ctrl;

    // Legality is settled in DECODE, so only the low bits are kept.
    if (OP_W > 3) begin : g_hi
        assign op_hi = |opcode[OP_W-1:3];
    end else begin : g_nohi
        assign op_hi = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (op_hi) begin
                    state_d = S_TRAP;
                end else begin
                    case (opcode[2:0])
                        OP_LW, OP_SW:    state_d = S_MEMADR;
                        OP_R:            state_d = S_EXEC;
                        OP_ADDI, OP_ORI: state_d = S_IMMEX;
                        OP_BEQ:          state_d = S_BRANCH;
                        OP_J:            state_d = ENABLE_JUMP ? S_JUMP
                                                               : S_TRAP;
                        default:         state_d = S_TRAP;
                    endcase
                end
            end
            S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_IMMWB;
            S_MEMWB, S_ALUWB, S_IMMWB,
            S_BRANCH, S_JUMP, S_TRAP:
                      state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    assign retire = (state_q == S_MEMWB)
                  | ((state_q == S_MEMWR) & mem_ready)
                  | (state_q == S_ALUWB)
                  | (state_q == S_IMMWB)
                  | (state_q == S_BRANCH)
                  | (state_q == S_JUMP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= opcode[2:0];
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    mcu_out_decode u_out_decode (
        .state     (state_q),
        .op        (op_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_src        = ctrl.pc_src;
    assign illegal       = ctrl.illegal;
    assign retired       = retired_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: a default unit and a jump-disabled, 4-bit-counter
// unit run the same instruction stream cycle by cycle.
module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;

    logic a_pw, a_pwc, a_iord, a_mr, a_mw, a_irw;
    logic a_m2r, a_rd, a_rw, a_sa, a_ill;
    logic [1:0] a_sb, a_ao, a_ps;
    logic [31:0] a_ret;
    logic [3:0] a_st;
    logic b_pw, b_pwc, b_iord, b_mr, b_mw, b_irw;
    logic b_m2r, b_rd, b_rw, b_sa, b_ill;
    logic [1:0] b_sb, b_ao, b_ps;
    logic [3:0] b_ret;
    logic [3:0] b_st;
    logic [16:0] a_out, b_out;

    assign a_out = {a_pw, a_pwc, a_iord, a_mr, a_mw, a_irw, a_m2r,
                    a_rd, a_rw, a_sa, a_sb, a_ao, a_ps, a_ill};
    assign b_out = {b_pw, b_pwc, b_iord, b_mr, b_mw, b_irw, b_m2r,
                    b_rd, b_rw, b_sa, b_sb, b_ao, b_ps, b_ill};

    always #5 clk = ~clk;

    multicycle_control_unit dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(a_pw), .pc_write_cond(a_pwc),
        .iord(a_iord), .mem_read(a_mr), .mem_write(a_mw),
        .ir_write(a_irw), .mem_to_reg(a_m2r), .reg_dst(a_rd),
        .reg_write(a_rw), .alu_src_a(a_sa), .alu_src_b(a_sb),
        .alu_op(a_ao), .pc_src(a_ps), .illegal(a_ill),
        .retired(a_ret), .state_o(a_st)
    );

    multicycle_control_unit #(
        .OP_W(6), .ENABLE_JUMP(1'b0), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(b_pw), .pc_write_cond(b_pwc),
        .iord(b_iord), .mem_read(b_mr), .mem_write(b_mw),
        .ir_write(b_irw), .mem_to_reg(b_m2r), .reg_dst(b_rd),
        .reg_write(b_rw), .alu_src_a(b_sa), .alu_src_b(b_sb),
        .alu_op(b_ao), .pc_src(b_ps), .illegal(b_ill),
        .retired(b_ret), .state_o(b_st)
    );

    typedef struct {
        logic        rdy;
        logic        z;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [16:0] out;
        logic [31:0] ret;
        logic [3:0]  st2;
        logic [16:0] out2;
        logic [3:0]  ret2;
    } item_t;

    item_t q[$];
    item_t it;
    logic [31:0] exp_r1;
    logic [3:0] exp_r2;
    logic pz;
    int checks = 0;
    int errors = 0;

    // Reference strobes straight from the per-state output table.
    function automatic logic [16:0] exp_out(state_t s, logic [2:0] op,
                                            logic rdy);
        logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ill;
        logic [1:0] sb, ao, ps;
        {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (s)
            S_FETCH:  begin mr = 1; if (rdy) begin
                          irw = 1; pw = 1; sb = 2'b01; end end
            S_DECODE: sb = 2'b11;
            S_MEMADR: begin sa = 1; sb = 2'b10; end
            S_MEMRD:  begin mr = 1; io = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin mw = 1; io = 1; end
            S_EXEC:   begin sa = 1; ao = 2'b10; end
            S_ALUWB:  begin rw = 1; rd = 1; end
            S_IMMEX:  begin sa = 1; sb = 2'b10;
                          ao = (op == 3'd7) ? 2'b11 : 2'b00; end
            S_IMMWB:  rw = 1;
            S_BRANCH: begin sa = 1; ao = 2'b01; pwc = 1;
                          ps = 2'b01; end
            S_JUMP:   begin pw = 1; ps = 2'b10; end
            S_TRAP:   ill = 1;
            default:  ill = 0;
        endcase
        return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa,
                sb, ao, ps, ill};
    endfunction

    task automatic push(input logic rdy, input state_t s,
                        input logic [5:0] drv, input logic [2:0] lop);
        item_t e;
        state_t s2;
        s2 = (s == S_JUMP) ? S_TRAP : s;
        e.rdy = rdy; e.z = pz; e.op = drv;
        e.st = s; e.out = exp_out(s, lop, rdy); e.ret = exp_r1;
        e.st2 = s2; e.out2 = exp_out(s2, lop, rdy); e.ret2 = exp_r2;
        q.push_back(e);
    endtask

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic logic rrdy();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic plan(input logic [5:0] op, input int fst,
                        input int mst);
        logic [2:0] lo;
        logic ill1, ill2;
        lo = op[2:0];
        ill1 = (op[5:3] != 3'd0) || (lo == 3'd3);
        ill2 = ill1 || (lo == 3'd2);
        for (int i = 0; i < fst; i++) push(1'b0, S_FETCH, rop(), lo);
        push(1'b1, S_FETCH, rop(), lo);
        push(rrdy(), S_DECODE, op, lo);
        if (ill1) push(rrdy(), S_TRAP, rop(), lo);
        else case (lo)
            3'd4: begin
                push(rrdy(), S_MEMADR, rop(), lo);
                for (int i = 0; i < mst; i++)
                    push(1'b0, S_MEMRD, rop(), lo);
                push(1'b1, S_MEMRD, rop(), lo);
                push(rrdy(), S_MEMWB, rop(), lo);
            end
            3'd5: begin
                push(rrdy(), S_MEMADR, rop(), lo);
                for (int i = 0; i < mst; i++)
                    push(1'b0, S_MEMWR, rop(), lo);
                push(1'b1, S_MEMWR, rop(), lo);
            end
            3'd0: begin
                push(rrdy(), S_EXEC, rop(), lo);
                push(rrdy(), S_ALUWB, rop(), lo);
            end
            3'd6: push(rrdy(), S_BRANCH, rop(), lo);
            3'd2: push(rrdy(), S_JUMP, rop(), lo);
            default: begin
                push(rrdy(), S_IMMEX, rop(), lo);
                push(rrdy(), S_IMMWB, rop(), lo);
            end
        endcase
        if (!ill1) exp_r1 = exp_r1 + 32'd1;
        if (!ill2) exp_r2 = exp_r2 + 4'd1;
    endtask

    task automatic step();
        @(posedge clk); #1;
        mem_ready = it.rdy; opcode = it.op; zero = it.z;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b0;
        q.delete(); exp_r1 = '0; exp_r2 = '0; pz = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_r1 = '0; exp_r2 = '0; pz = 1'b0;
        #2;
        checks++;
        if ({a_st, a_out, a_ret} !== {4'd0, exp_out(S_FETCH, 3'd0, 1'b0),
                                      32'd0}) begin
            errors++;
            $display("FAIL reset_a: st=%0d out=%h ret=%0d want st=0 out=%h ret=0",
                     a_st, a_out, a_ret, exp_out(S_FETCH, 3'd0, 1'b0));
        end
        checks++;
        if ({b_st, b_ret} !== 8'd0) begin
            errors++;
            $display("FAIL reset_b: st=%0d ret=%0d want 0 0", b_st, b_ret);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_st !== 4'(S_FETCH)) begin
            errors++;
            $display("FAIL reset_release: st=%0d want %0d", a_st, S_FETCH);
        end
    endtask

    task automatic test_reset_abort();
        plan(6'd4, 0, 3);
        while (q.size() != 0) begin
            it = q.pop_front();
            step();
            checks++;
            if ({a_st, a_out, a_ret} !== {it.st, it.out, it.ret}) begin
                errors++;
                $display("FAIL abort_seq: st=%0d out=%h ret=%0d want st=%0d out=%h ret=%0d",
                         a_st, a_out, a_ret, it.st, it.out, it.ret);
            end
            if (it.st == 4'(S_MEMRD)) break;
        end
        #1 rst_n = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if ({a_st, a_rw, a_ret, b_st, b_ret} !==
            {4'(S_FETCH), 1'b0, 32'd0, 4'(S_FETCH), 4'd0}) begin
            errors++;
            $display("FAIL abort_async: st=%0d rw=%b ret=%0d b_st=%0d want FETCH 0 0",
                     a_st, a_rw, a_ret, b_st);
        end
        q.delete(); exp_r1 = '0; exp_r2 = '0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({a_st, a_rw, a_ret} !== {4'(S_FETCH), 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL abort_after: st=%0d rw=%b ret=%0d want FETCH 0 0",
                     a_st, a_rw, a_ret);
        end
    endtask

    task automatic test_lw();
        do_reset();
        plan(6'd4, 0, 0);
        while (q.size() != 0) begin
            it = q.pop_front();
            step();
            checks++;
            if ({a_st, a_out, a_ret} !== {it.st, it.out, it.ret}) begin
                errors++;
                $display("FAIL lw_seq: st=%0d out=%h ret=%0d want st=%0d out=%h ret=%0d",
                         a_st, a_out, a_ret, it.st, it.out, it.ret);
            end
        end
        @(posedge clk); #1 mem_ready = 1'b0;
        checks++;
        if (a_ret !== 32'd1) begin
            errors++;
            $display("FAIL lw_retired: got %0d want 1", a_ret);
        end
    endtask

    task automatic test_sw_stall();
        int n, mw;
        n = 0; mw = 0;
        plan(6'd5, 0, 3);
        while (q.size() != 0) begin
            it = q.pop_front();
            step();
            n++;
            if (a_mw) mw++;
            checks++;
            if ({a_st, a_out, a_ret, b_st, b_out, b_ret} !==
                {it.st, it.out, it.ret, it.st2, it.out2, it.ret2}) begin
                errors++;
                $display("FAIL sw_seq: st=%0d out=%h ret=%0d want st=%0d out=%h ret=%0d",
                         a_st, a_out, a_ret, it.st, it.out, it.ret);
            end
        end
        checks++;
        if (n != 7 || mw != 4) begin
            errors++;
            $display("FAIL sw_len: cycles=%0d mem_write=%0d want 7 4", n, mw);
        end
    endtask

    task automatic test_alu();
        plan(6'd0, 2, 0);
        plan(6'd1, 0, 0);
        plan(6'd7, 1, 0);
        while (q.size() != 0) begin
            it = q.pop_front();
            step();
            checks++;
            if ({a_st, a_out, a_ret, b_st, b_out, b_ret} !==
                {it.st, it.out, it.ret, it.st2, it.out2, it.ret2}) begin
                errors++;
                $display("FAIL alu_seq: st=%0d out=%h ret=%0d want st=%0d out=%h ret=%0d",
                         a_st, a_out, a_ret, it.st, it.out, it.ret);
            end
        end
    endtask

    task automatic test_back_to_back_beq();
        int nb;
        nb = 0;
        do_reset();
        pz = 1'b0; plan(6'd6, 0, 0);
        pz = 1'b1; plan(6'd6, 0, 0);
        while (q.size() != 0) begin
            it = q.pop_front();
            step();
            if (a_pwc && a_ps == 2'b01) nb++;
            checks++;
            if ({a_st, a_out, a_ret, b_st, b_out, b_ret} !==
                {it.st, it.out, it.ret, it.st2, it.out2, it.ret2}) begin
                errors++;
                $display("FAIL beq_seq: st=%0d out=%h ret=%0d want st=%0d out=%h ret=%0d",
                         a_st, a_out, a_ret, it.st, it.out, it.ret);
            end
        end
        @(posedge clk); #1 mem_ready = 1'b0;
        checks++;
        if (a_ret !== 32'd2 || nb != 2) begin
            errors++;
            $display("FAIL beq_retired: ret=%0d branches=%0d want 2 2",
                     a_ret, nb);
        end
    endtask

    task automatic test_illegal();
        int ia, ib;
        ia = 0; ib = 0;
        plan(6'd8, 0, 0);
        plan(6'd2, 0, 0);
        plan(6'd3, 1, 0);
        while (q.size() != 0) begin
            it = q.pop_front();
            step();
            if (a_ill) ia++;
            if (b_ill) ib++;
            checks++;
            if ({a_st, a_out, a_ret, b_st, b_out, b_ret} !==
                {it.st, it.out, it.ret, it.st2, it.out2, it.ret2}) begin
                errors++;
                $display("FAIL illegal_seq: st=%0d/%0d out=%h/%h want %0d/%0d %h/%h",
                         a_st, b_st, a_out, b_out, it.st, it.st2,
                         it.out, it.out2);
            end
        end
        checks++;
        if (ia != 2 || ib != 3) begin
            errors++;
            $display("FAIL illegal_count: a=%0d b=%0d want 2 3", ia, ib);
        end
    endtask

    task automatic test_wrap();
        logic saw15;
        saw15 = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) plan(6'd0, 0, 0);
        while (q.size() != 0) begin
            it = q.pop_front();
            step();
            if (b_ret == 4'd15) saw15 = 1'b1;
            checks++;
            if ({b_st, b_out, b_ret} !== {it.st2, it.out2, it.ret2}) begin
                errors++;
                $display("FAIL wrap_seq: st=%0d out=%h ret=%0d want st=%0d out=%h ret=%0d",
                         b_st, b_out, b_ret, it.st2, it.out2, it.ret2);
            end
        end
        @(posedge clk); #1 mem_ready = 1'b0;
        checks++;
        if (b_ret !== 4'd0 || !saw15 || a_ret !== 32'd16) begin
            errors++;
            $display("FAIL wrap_end: b_ret=%0d saw15=%b a_ret=%0d want 0 1 16",
                     b_ret, saw15, a_ret);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_abort();
        test_lw();
        test_sw_stall();
        test_alu();
        test_back_to_back_beq();
        test_illegal();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
